// File: rtl/aes_inv_mix_columns_if.sv
// Block handshake bundle for the InvMixColumns stage: input block in, result block out.
// The master drives blocks and out_ready; the slave (the datapath) answers with ready/valid/result.
interface aes_inv_mix_columns_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         in_bypass;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;

  modport master (
    output in_valid, in_data, in_bypass, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_bypass, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/aes_inv_mix_columns.sv
// AES InvMixColumns, one column per cycle: 5 edges accept->out_valid (1 edge when bypassed).
// Single block in flight; in_ready only in IDLE, result held in OUT until out_ready.
module aes_inv_mix_columns #(
  parameter bit BYTE_MSB_FIRST = 1'b1
) (
  input logic                  clk,
  input logic                  rst,
  aes_inv_mix_columns_if.slave bus_io
);

  typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;

  state_t       state_q;
  logic [127:0] data_q;
  logic [127:0] data_d;
  logic [1:0]   col_cnt_q;
  logic         bypass_q;
  logic         out_valid_q;
  logic [127:0] in_canon;

  function automatic logic [127:0] byte_rev(input logic [127:0] d);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) begin
      r[8*k +: 8] = d[127-8*k -: 8];
    end
    return r;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Column packed with row 0 in the top byte.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a [4];
    logic [7:0] m9 [4];
    logic [7:0] m11 [4];
    logic [7:0] m13 [4];
    logic [7:0] m14 [4];
    logic [7:0] x2, x4, x8;
    for (int r = 0; r < 4; r++) begin
      a[r]   = col[31-8*r -: 8];
      x2     = xtime(a[r]);
      x4     = xtime(x2);
      x8     = xtime(x4);
      m9[r]  = x8 ^ a[r];
      m11[r] = x8 ^ x2 ^ a[r];
      m13[r] = x8 ^ x4 ^ a[r];
      m14[r] = x8 ^ x4 ^ x2;
    end
    return {m14[0] ^ m11[1] ^ m13[2] ^ m9[3],
            m9[0]  ^ m14[1] ^ m11[2] ^ m13[3],
            m13[0] ^ m9[1]  ^ m14[2] ^ m11[3],
            m11[0] ^ m13[1] ^ m9[2]  ^ m14[3]};
  endfunction

  // Internally the state is always held MSB-first; the parameter only swaps at the ports.
  assign in_canon = BYTE_MSB_FIRST ? bus_io.in_data : byte_rev(bus_io.in_data);

  always_comb begin
    data_d = data_q;
    for (int c = 0; c < 4; c++) begin
      if (col_cnt_q == 2'(c)) begin
        data_d[127-32*c -: 32] = inv_mix_col(data_q[127-32*c -: 32]);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      data_q      <= '0;
      col_cnt_q   <= '0;
      bypass_q    <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus_io.in_valid) begin
            data_q    <= in_canon;
            bypass_q  <= bus_io.in_bypass;
            col_cnt_q <= '0;
            if (bus_io.in_bypass) begin
              state_q     <= OUT;
              out_valid_q <= 1'b1;
            end else begin
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          if (!bypass_q) begin
            data_q <= data_d;
          end
          col_cnt_q <= col_cnt_q + 2'd1;
          if (col_cnt_q == 2'd3) begin
            state_q     <= OUT;
            out_valid_q <= 1'b1;
          end
        end
        OUT: begin
          if (bus_io.out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus_io.in_ready  = (state_q == IDLE) && !rst;
  assign bus_io.out_valid = out_valid_q;
  assign bus_io.out_data  = BYTE_MSB_FIRST ? data_q : byte_rev(data_q);

endmodule

// File: tb/tb_aes_inv_mix_columns.sv
// Directed bench for aes_inv_mix_columns: known InvMixColumns vectors, bypass, stall, reset, streaming.
module tb_aes_inv_mix_columns;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  aes_inv_mix_columns_if bus ();

  aes_inv_mix_columns #(.BYTE_MSB_FIRST(1'b1)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [127:0] V1 = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] E1 = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] V2 = 128'hd5d5d7d6_00000000_ffffffff_01010101;
  localparam logic [127:0] E2 = 128'hd4d4d4d5_00000000_ffffffff_01010101;
  localparam logic [127:0] V3 = 128'hd5d5d7d6_8e4da1bc_01010101_9fdc589d;
  localparam logic [127:0] E3 = 128'hd4d4d4d5_db135345_01010101_f20a225c;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Accept one block, check out_valid stays low until the expected edge, then stall and drain.
  task automatic run_block(input string tag, input logic [127:0] din, input logic byp,
                           input logic [127:0] exp, input int lat, input int stall);
    bus.in_valid  = 1'b1;
    bus.in_data   = din;
    bus.in_bypass = byp;
    bus.out_ready = 1'b0;
    chk({tag, "_rdy_before"}, 128'(bus.in_ready), 128'd1);
    tick();
    bus.in_valid = 1'b0;
    for (int i = 1; i < lat; i++) begin
      chk({tag, "_early_vld"}, 128'(bus.out_valid), 128'd0);
      chk({tag, "_busy_rdy"}, 128'(bus.in_ready), 128'd0);
      tick();
    end
    chk({tag, "_vld"}, 128'(bus.out_valid), 128'd1);
    chk({tag, "_data"}, bus.out_data, exp);
    for (int i = 0; i < stall; i++) begin
      bus.in_valid  = i[0];
      bus.in_data   = ~din;
      bus.in_bypass = 1'b1;
      tick();
      chk({tag, "_stall_vld"}, 128'(bus.out_valid), 128'd1);
      chk({tag, "_stall_data"}, bus.out_data, exp);
      chk({tag, "_stall_rdy"}, 128'(bus.in_ready), 128'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk({tag, "_drain_vld"}, 128'(bus.out_valid), 128'd0);
    chk({tag, "_drain_rdy"}, 128'(bus.in_ready), 128'd1);
  endtask

  initial begin
    logic [127:0] vec [3];
    logic [127:0] exp [3];
    int           acc_cyc [3];
    int           idx;
    int           oi;
    logic         acc;

    n_cmp  = 0;
    n_fail = 0;
    rst    = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_bypass = 1'b0;
    bus.out_ready = 1'b0;

    #3;
    chk("rst_in_ready", 128'(bus.in_ready), 128'd0);
    chk("rst_out_valid", 128'(bus.out_valid), 128'd0);
    chk("rst_out_data", bus.out_data, 128'd0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 128'(bus.in_ready), 128'd1);

    run_block("v1", V1, 1'b0, E1, 5, 0);
    run_block("v2", V2, 1'b0, E2, 5, 0);
    run_block("v1_bypass", V1, 1'b1, V1, 1, 0);
    run_block("v1_stall", V1, 1'b0, E1, 5, 10);

    // Reset while the third column is about to be transformed.
    bus.in_valid  = 1'b1;
    bus.in_data   = V2;
    bus.in_bypass = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("midcalc_rst_vld", 128'(bus.out_valid), 128'd0);
    chk("midcalc_rst_data", bus.out_data, 128'd0);
    chk("midcalc_rst_rdy", 128'(bus.in_ready), 128'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("midcalc_release_rdy", 128'(bus.in_ready), 128'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("midcalc_no_vld", 128'(bus.out_valid), 128'd0);
    end
    run_block("after_rst", V2, 1'b0, E2, 5, 0);

    // Streaming: in_valid and out_ready held high over three blocks.
    vec[0] = V1; vec[1] = V2; vec[2] = V3;
    exp[0] = E1; exp[1] = E2; exp[2] = E3;
    acc_cyc[0] = 0; acc_cyc[1] = 0; acc_cyc[2] = 0;
    idx = 0;
    oi  = 0;
    bus.out_ready = 1'b1;
    bus.in_bypass = 1'b0;
    bus.in_data   = vec[0];
    for (int cyc = 0; cyc < 25; cyc++) begin
      bus.in_valid = (idx < 3);
      acc = bus.in_ready && (idx < 3);
      tick();
      if (acc) begin
        acc_cyc[idx] = cyc;
        idx++;
        if (idx < 3) bus.in_data = vec[idx];
      end
      if (bus.out_valid) begin
        if (oi < 3) chk("stream_data", bus.out_data, exp[oi]);
        oi++;
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    chk("stream_accepts", 128'(idx), 128'd3);
    chk("stream_results", 128'(oi), 128'd3);
    chk("stream_gap01", 128'(acc_cyc[1] - acc_cyc[0]), 128'd6);
    chk("stream_gap12", 128'(acc_cyc[2] - acc_cyc[1]), 128'd6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
